fib_driver: RTL and testbench

//  Initiator side of the fib core strobe/busy interface. Accepts iteration-count

---
 rtl/fib_driver_if.sv | 12 +
 rtl/fib_driver.sv | 168 ++++++++++++++++
 tb/tb_fib_driver.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_driver_if.sv
// Strobe/busy link between the fib driver (master) and one fib core (slave).
interface fib_driver_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             stb;
  logic             busy;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] fib;

  modport master (output stb, output n, input busy, input fib);
  modport slave  (input stb, input n, output busy, output fib);
endinterface

// File: rtl/fib_driver.sv
// Fib core initiator: accepts n on valid/ready, strobes the core, queues results.
// Optional WAIT timeout with DRAIN state when FIB_DRV_TIMEOUT_EN is defined.
module fib_driver #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned RES_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_n,
  fib_driver_if.master     core,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_fib,
  output logic [WIDTH-1:0] o_res_n,
  output logic             o_res_err,
  output logic [15:0]      o_done_cnt
);

  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef FIB_DRV_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
`ifdef FIB_DRV_TIMEOUT_EN
    S_DRAIN,
`endif
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] fib;
    logic [WIDTH-1:0] n;
    logic             err;
  } res_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             stb_q;
  logic             push, push_err, pop, accept;
  res_t             push_entry;
  res_t             mem_q [RES_DEPTH];
  res_t             head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic [15:0]      done_q;
`ifdef FIB_DRV_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Capture space is reserved at accept time: only one transaction is ever in flight.
  assign o_req_ready = !i_reset && (state_q == S_IDLE) && (count_q < CNT_W'(RES_DEPTH));
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin : fsm_next
    state_d  = state_q;
    n_d      = n_q;
    push     = 1'b0;
    push_err = 1'b0;
`ifdef FIB_DRV_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d     = i_req_n;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: begin
        state_d = S_WAIT;
`ifdef FIB_DRV_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (!core.busy) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
`ifdef FIB_DRV_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
`ifdef FIB_DRV_TIMEOUT_EN
      S_DRAIN: begin
        if (!core.busy) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fifo_next
    push_entry.fib = push_err ? '0 : core.fib;
    push_entry.n   = n_q;
    push_entry.err = push_err;
    pop      = valid_q && i_res_ready;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Output register follows the next head; bypass when that head is written this cycle.
    if (count_d == '0)
      head_d = head_q;
    else if (push && (rd_ptr_d == wr_ptr_q))
      head_d = push_entry;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge i_clk) begin : state_regs
    if (i_reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      stb_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      done_q   <= '0;
`ifdef FIB_DRV_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      stb_q    <= (state_d == S_ISSUE);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
      done_q   <= done_q + 16'(push);
`ifdef FIB_DRV_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin : fifo_mem
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign core.stb    = stb_q;
  assign core.n      = n_q;
  assign o_res_valid = valid_q;
  assign o_res_fib   = head_q.fib;
  assign o_res_n     = head_q.n;
  assign o_res_err   = head_q.err;
  assign o_done_cnt  = done_q;

endmodule

// File: tb/tb_fib_driver.sv
// Self-checking bench for fib_driver with a behavioural fib core model.
module tb_fib_driver;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, res_valid, res_ready, res_err;
  logic [W-1:0]  req_n, res_fib, res_n;
  logic [15:0]   done_cnt;

  fib_driver_if #(.WIDTH(W)) core_bus ();

  fib_driver #(.WIDTH(W), .RES_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_n(req_n),
    .core(core_bus.master),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_fib(res_fib), .o_res_n(res_n), .o_res_err(res_err),
    .o_done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Core model: registers the strobe, then busy for n cycles; result fib(n).
  logic         dly = 1'b0;
  logic         stuck = 1'b0;
  int unsigned  pend_n = 0, bcnt = 0;
  logic [W-1:0] fib_q = '0;

  function automatic logic [W-1:0] fib_fn(input logic [W-1:0] k);
    logic [W-1:0] a, b, t;
    a = '0; b = W'(1);
    for (int i = 0; i < int'(k); i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  always @(posedge clk) begin
    dly <= core_bus.stb;
    if (core_bus.stb) begin
      pend_n <= core_bus.n;
      fib_q  <= fib_fn(core_bus.n);
    end
    if (dly) bcnt <= pend_n;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign core_bus.busy = (bcnt != 0) || stuck;
  assign core_bus.fib  = fib_q;

  int errors = 0, checks = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send_req(input logic [W-1:0] n);
    int k;
    req_valid = 1'b1; req_n = n; k = 0;
    while (!req_ready && k < 200) begin tick(); k++; end
    if (!req_ready) chk("accept_timeout", 64'(0), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  // Wait for the FIFO to show a result; count strobes seen on the way.
  task automatic wait_result(input logic [W-1:0] n, output int lat, output int stbs);
    lat = 0; stbs = 0;
    while (!res_valid && lat < 200) begin
      if (core_bus.stb) begin
        stbs++;
        chk("core_n_at_stb", 64'(core_bus.n), 64'(n));
      end
      tick(); lat++;
    end
    if (!res_valid) chk("result_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (int'(done_cnt) != target && k < 200) begin tick(); k++; end
    chk("done_wait", 64'(done_cnt), 64'(target));
  endtask

  task automatic pop_chk(input string name, input logic [W-1:0] f, input logic [W-1:0] n);
    chk({name, "_valid"}, 64'(res_valid), 64'(1));
    chk({name, "_fib"}, 64'(res_fib), 64'(f));
    chk({name, "_n"}, 64'(res_n), 64'(n));
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] fib;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, stbs, tally;
    vecs[0] = '{n: 10, fib: 55,    lat: 13};
    vecs[1] = '{n: 0,  fib: 0,     lat: 3};
    vecs[2] = '{n: 1,  fib: 1,     lat: 4};
    vecs[3] = '{n: 2,  fib: 1,     lat: 5};
    vecs[4] = '{n: 7,  fib: 13,    lat: 10};
    vecs[5] = '{n: 24, fib: 46368, lat: 27};

    rst = 1'b1; req_valid = 1'b0; req_n = '0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_stb", 64'(core_bus.stb), 64'(0));
    chk("rst_n", 64'(core_bus.n), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_fib", 64'(res_fib), 64'(0));
    chk("rst_res_n", 64'(res_n), 64'(0));
    chk("rst_res_err", 64'(res_err), 64'(0));
    chk("rst_done", 64'(done_cnt), 64'(0));
    rst = 1'b0; #1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));

    // Single requests, each drained before the next.
    for (int v = 0; v < 6; v++) begin
      send_req(vecs[v].n);
      wait_result(vecs[v].n, lat, stbs);
      exp_done++;
      chk("vec_latency", 64'(lat), 64'(vecs[v].lat));
      chk("vec_stb_count", 64'(stbs), 64'(1));
      chk("vec_fib", 64'(res_fib), 64'(vecs[v].fib));
      chk("vec_n", 64'(res_n), 64'(vecs[v].n));
      chk("vec_err", 64'(res_err), 64'(0));
      chk("vec_done", 64'(done_cnt), 64'(exp_done));
      chk("vec_ready_after", 64'(req_ready), 64'(1));
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("vec_popped", 64'(res_valid), 64'(0));
    end

    // Busy in IDLE has no effect.
    stuck = 1'b1; tally = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_bus.stb || res_valid || !req_ready) tally++;
    end
    stuck = 1'b0;
    chk("idle_busy_ignored", 64'(tally), 64'(0));
    chk("idle_busy_done", 64'(done_cnt), 64'(exp_done));

    // Fill the FIFO, fifth request blocked until a pop.
    for (int k = 1; k <= 4; k++) begin
      send_req(W'(k));
      exp_done++;
      wait_done(exp_done);
    end
    req_valid = 1'b1; req_n = W'(5); tally = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) tally++;
      tick();
    end
    chk("full_ready_low", 64'(tally), 64'(0));
    pop_chk("full_pop1", 1, 1);
    chk("room_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    pop_chk("full_pop2", 1, 2);
    pop_chk("full_pop3", 2, 3);
    pop_chk("full_pop4", 3, 4);
    wait_result(W'(5), lat, stbs);
    exp_done++;
    pop_chk("full_pop5", 5, 5);
    chk("full_empty", 64'(res_valid), 64'(0));

    // Push and pop in the same cycle at 3/4 occupancy, across pointer wrap.
    for (int k = 6; k <= 8; k++) begin
      send_req(W'(k));
      exp_done++;
      wait_done(exp_done);
    end
    send_req(W'(9));
    for (int i = 0; i < 11; i++) tick();
    chk("pp_before_push", 64'(done_cnt), 64'(exp_done));
    chk("pp_head", 64'(res_fib), 64'(8));
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    exp_done++;
    chk("pp_push_same_edge", 64'(done_cnt), 64'(exp_done));
    chk("pp_ready_room", 64'(req_ready), 64'(1));
    pop_chk("pp_pop1", 13, 7);
    pop_chk("pp_pop2", 21, 8);
    pop_chk("pp_pop3", 34, 9);
    chk("pp_empty", 64'(res_valid), 64'(0));

    // Reset during WAIT discards everything.
    send_req(W'(3));
    exp_done++;
    wait_done(exp_done);
    send_req(W'(20));
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    chk("mid_rst_valid", 64'(res_valid), 64'(0));
    chk("mid_rst_done", 64'(done_cnt), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_n", 64'(core_bus.n), 64'(0));
    rst = 1'b0; #1;
    exp_done = 0;
    chk("mid_rst_idle", 64'(req_ready), 64'(1));
    tally = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (res_valid || done_cnt != 16'd0 || core_bus.stb) tally++;
    end
    chk("mid_rst_no_push", 64'(tally), 64'(0));
    send_req(W'(5));
    wait_result(W'(5), lat, stbs);
    exp_done++;
    chk("recover_lat", 64'(lat), 64'(8));
    chk("recover_done", 64'(done_cnt), 64'(exp_done));
    pop_chk("recover_pop", 5, 5);

`ifdef FIB_DRV_TIMEOUT_EN
    // Core stuck busy: error entry after 8 WAIT cycles, then DRAIN until busy falls.
    send_req(W'(3));
    stuck = 1'b1;
    wait_result(W'(3), lat, stbs);
    exp_done++;
    chk("tmo_lat", 64'(lat), 64'(10));
    chk("tmo_err", 64'(res_err), 64'(1));
    chk("tmo_fib", 64'(res_fib), 64'(0));
    chk("tmo_n", 64'(res_n), 64'(3));
    chk("tmo_done", 64'(done_cnt), 64'(exp_done));
    tally = 0;
    for (int i = lat; i < 50; i++) begin
      if (req_ready) tally++;
      tick();
    end
    chk("drain_ready_low", 64'(tally), 64'(0));
    stuck = 1'b0;
    tick();
    chk("drain_exit", 64'(req_ready), 64'(1));
    pop_chk("tmo_pop", 0, 3);
    chk("tmo_late_discarded", 64'(res_valid), 64'(0));
    chk("tmo_done_final", 64'(done_cnt), 64'(exp_done));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
